// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=a .. bit0=g)
// and the BCD "no digit" marker used by display checkers.
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG7_D0    = 7'b0000001;
  localparam seg7_t SEG7_D1    = 7'b1001111;
  localparam seg7_t SEG7_D2    = 7'b0010010;
  localparam seg7_t SEG7_D3    = 7'b0000110;
  localparam seg7_t SEG7_D4    = 7'b1001100;
  localparam seg7_t SEG7_D5    = 7'b0100100;
  localparam seg7_t SEG7_D6    = 7'b0100000;
  localparam seg7_t SEG7_D7    = 7'b0001111;
  localparam seg7_t SEG7_D8    = 7'b0000000;
  localparam seg7_t SEG7_D9    = 7'b0000100;
  localparam seg7_t SEG7_BLANK = 7'b1111111;

  localparam bcd_t DIGIT_NONE = 4'hF;
endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern -> BCD decoder. Blank and unknown patterns
// both return DIGIT_NONE; the legal/blank flags tell them apart.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       legal,
  output logic       blank
);

  // Table lookup against the package codes
  always_comb begin
    value = DIGIT_NONE;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG7_D0:    value = 4'd0;
      SEG7_D1:    value = 4'd1;
      SEG7_D2:    value = 4'd2;
      SEG7_D3:    value = 4'd3;
      SEG7_D4:    value = 4'd4;
      SEG7_D5:    value = 4'd5;
      SEG7_D6:    value = 4'd6;
      SEG7_D7:    value = 4'd7;
      SEG7_D8:    value = 4'd8;
      SEG7_D9:    value = 4'd9;
      SEG7_BLANK: begin legal = 1'b0; blank = 1'b1; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loop-back monitor for a multiplexed active-low 7-segment bus. Each stable
// dwell of {an,seg7} is captured once and decoded into per-digit values and
// status. Optional macro SEG7_ERRCNT_EN adds a saturating err_count output.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg7,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    pattern_err,
  output logic                    an_err,
`ifdef SEG7_ERRCNT_EN
  output logic [7:0]              err_count,
`endif
  output logic                    frame_done
);

  localparam logic [7:0]            RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = 1;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic [7:0]              run_q, run_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d, seen_q, seen_d;
  logic                    perr_q, perr_d, anerr_q, anerr_d, frame_q, frame_d;
  logic [3:0]              dec_value;
  logic                    dec_legal, dec_blank, dec_invalid;
  logic [NUM_DIGITS-1:0]   an_low;
  logic                    in_same, capture, multi_low, single_low;

  seg7_pattern_decode u_dec (
    .seg   (seg_q),
    .value (dec_value),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  // Run length of the current {an,seg7} and the one-shot capture strobe
  always_comb begin
    in_same     = ({an, seg7} == {an_q, seg_q});
    run_d       = !in_same ? 8'd1 : ((run_q == RUN_MAX) ? run_q : run_q + 8'd1);
    capture     = in_same && (run_q == RUN_MAX - 8'd1);
    an_low      = ~an_q;
    multi_low   = |(an_low & (an_low - AN_ONE));
    single_low  = (|an_low) && !multi_low;
    dec_invalid = !dec_legal && !dec_blank;
  end

  // Per-digit capture, sticky flags and frame tracking
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    perr_d   = perr_q;
    anerr_d  = anerr_q;
    frame_d  = &seen_q;
    // A full mask is consumed by the frame pulse; a same-cycle capture
    // starts the next frame.
    seen_d   = (&seen_q) ? '0 : seen_q;
    if (capture) begin
      if (multi_low) begin
        anerr_d = 1'b1;
      end else if (single_low) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_low[i]) begin
            digits_d[4*i +: 4] = dec_value;
            valid_d[i]         = dec_legal;
            blank_d[i]         = dec_blank;
            seen_d[i]          = 1'b1;
          end
        end
        if (dec_invalid) perr_d = 1'b1;
      end
    end
  end

`ifdef SEG7_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // One count per erroneous capture, saturating
  always_comb begin
    errcnt_d = errcnt_q;
    if (capture && (multi_low || (single_low && dec_invalid)) && errcnt_q != 8'hFF)
      errcnt_d = errcnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errcnt_q <= 8'd0;
    else        errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

  // Sample stage and capture state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= '1;
      seg_q    <= '1;
      run_q    <= 8'd0;
      digits_q <= {NUM_DIGITS{DIGIT_NONE}};
      valid_q  <= '0;
      blank_q  <= '0;
      seen_q   <= '0;
      perr_q   <= 1'b0;
      anerr_q  <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      an_q     <= an;
      seg_q    <= seg7;
      run_q    <= run_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      seen_q   <= seen_d;
      perr_q   <= perr_d;
      anerr_q  <= anerr_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign pattern_err = perr_q;
  assign an_err      = anerr_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected snapshots are queued when a
// dwell is driven and popped on the edge where the capture must land.
module tb_seg7_scan_decoder;
  localparam int STB = 4;

  typedef struct {
    logic [15:0] dg;
    logic [3:0]  v;
    logic [3:0]  b;
    logic        pe;
    logic        ae;
    logic        fd;
    logic [7:0]  ec;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg7;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid, digit_blank;
  logic        pattern_err, an_err, frame_done;
`ifdef SEG7_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;
  snap_t q[$];
  snap_t cur;
  logic [6:0] codes [10];

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(STB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg7        (seg7),
    .an          (an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .pattern_err (pattern_err),
    .an_err      (an_err),
`ifdef SEG7_ERRCNT_EN
    .err_count   (err_count),
`endif
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input snap_t s, input logic fd);
    chk("digits", 32'(digits), 32'(s.dg));
    chk("digit_valid", 32'(digit_valid), 32'(s.v));
    chk("digit_blank", 32'(digit_blank), 32'(s.b));
    chk("pattern_err", 32'(pattern_err), 32'(s.pe));
    chk("an_err", 32'(an_err), 32'(s.ae));
    chk("frame_done", 32'(frame_done), 32'(fd));
`ifdef SEG7_ERRCNT_EN
    chk("err_count", 32'(err_count), 32'(s.ec));
`endif
  endtask

  task automatic reset_model();
    cur.dg = 16'hFFFF; cur.v = '0; cur.b = '0;
    cur.pe = 0; cur.ae = 0; cur.fd = 0; cur.ec = 8'd0;
  endtask

  // Expected result of a capture on single digit i with pattern s
  task automatic expect_cap(input int i, input logic [6:0] s, input bit fd);
    snap_t n = cur;
    logic [3:0] val = 4'hF;
    logic legal = 0;
    logic blank = (s == 7'b1111111);
    for (int k = 0; k < 10; k++)
      if (codes[k] == s) begin val = 4'(k); legal = 1; end
    n.dg[4*i +: 4] = val;
    n.v[i] = legal;
    n.b[i] = blank;
    if (!legal && !blank) begin
      n.pe = 1;
      if (n.ec != 8'hFF) n.ec = n.ec + 8'd1;
    end
    n.fd = fd;
    q.push_back(n);
  endtask

  task automatic expect_anerr();
    snap_t n = cur;
    n.ae = 1; n.fd = 0;
    if (n.ec != 8'hFF) n.ec = n.ec + 8'd1;
    q.push_back(n);
  endtask

  // Hold {a,s} for n edges; a capture (if any) must land on edge STB-1
  task automatic run_dwell(input logic [3:0] a, input logic [6:0] s, input int n, input bit cap);
    bit fd_pend = 0;
    an = a; seg7 = s;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (cap && k == STB - 1) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
          cur = q.pop_front();
          fd_pend = cur.fd;
        end
      end
      chk_state(cur, cap && fd_pend && (k == STB));
    end
  endtask

  initial begin
    codes[0] = 7'b0000001; codes[1] = 7'b1001111; codes[2] = 7'b0010010;
    codes[3] = 7'b0000110; codes[4] = 7'b1001100; codes[5] = 7'b0100100;
    codes[6] = 7'b0100000; codes[7] = 7'b0001111; codes[8] = 7'b0000000;
    codes[9] = 7'b0000100;
    reset_model();
    rst_n = 1'b0; an = 4'hF; seg7 = 7'h7F;
    repeat (2) @(posedge clk);
    #1 chk_state(cur, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // 1: single digit capture with 4-edge latency, no repeat capture
    expect_cap(0, codes[2], 0);
    run_dwell(4'b1110, codes[2], 6, 1);

    // 2: short glitch ignored, then the stable pattern captured
    run_dwell(4'b1101, codes[1], 2, 0);
    expect_cap(1, codes[3], 0);
    run_dwell(4'b1101, codes[3], 5, 1);

    // 3: full scan, frame_done one cycle after the last digit
    expect_cap(0, codes[0], 0); run_dwell(4'b1110, codes[0], 5, 1);
    expect_cap(1, codes[1], 0); run_dwell(4'b1101, codes[1], 5, 1);
    expect_cap(2, codes[2], 0); run_dwell(4'b1011, codes[2], 5, 1);
    expect_cap(3, codes[3], 1); run_dwell(4'b0111, codes[3], 5, 1);
    chk("digits_frame", 32'(digits), 32'h3210);

    // 4: illegal pattern, then blank on the same digit
    expect_cap(2, 7'b1111110, 0); run_dwell(4'b1011, 7'b1111110, 4, 1);
    expect_cap(2, 7'b1111111, 0); run_dwell(4'b1011, 7'b1111111, 4, 1);

    // 5: multiple enables low
    expect_anerr(); run_dwell(4'b1100, codes[0], 4, 1);
    expect_anerr(); run_dwell(4'b1001, codes[0], 4, 1);
`ifdef SEG7_ERRCNT_EN
    for (int r = 0; r < 150; r++) begin
      expect_anerr(); run_dwell(4'b1100, codes[5], 4, 1);
      expect_anerr(); run_dwell(4'b1001, codes[5], 4, 1);
    end
    chk("err_count_sat", 32'(err_count), 32'hFF);
`endif

    // 6: reset in the middle of a dwell
    an = 4'b0111; seg7 = codes[9];
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_model();
    chk_state(cur, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    expect_cap(3, codes[9], 0);
    run_dwell(4'b0111, codes[9], 5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Monitors a time-multiplexed, active-low 7-segment bus (segment lines plus per-digit enables) as driven toward the clock display.
- For each digit it waits for a stable pattern, decodes it back to a 4-bit BCD value, and keeps per-digit captured values and status flags.
- Used for display self-test and loop-back checking of the digit-drive path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (width of an).
- STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- seg7  input  7  segment lines, active-low; bit6=a … bit0=g
- an  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i
- digits  output  4*NUM_DIGITS  captured BCD values; digit i in bits [4i+3:4i]
- digit_valid  output  NUM_DIGITS  1 = digit i last captured a legal 0-9 pattern
- digit_blank  output  NUM_DIGITS  1 = digit i last captured all-off (7'b1111111)
- pattern_err  output  1  sticky: an illegal segment pattern was captured
- an_err  output  1  sticky: more than one an bit was low for STABLE_CYCLES samples
- frame_done  output  1  one-cycle pulse after every digit has been captured since the previous pulse

Behaviour:
- Reset (async, rst_n=0): digits=all 4'hF, digit_valid=0, digit_blank=0, pattern_err=0, an_err=0, frame_done=0, sample regs=all ones, run=0, seen mask=0.
- Decode table (7'b pattern → value): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
- 1111111 → blank; value field 4'hF.
- Any other pattern → invalid; value field 4'hF.
- Sample stage: {an,seg7} is registered every clk into {an_q,seg_q}.
- Run counter:
  - If the incoming {an,seg7} differs from {an_q,seg_q}, run<=1.
  - Otherwise run increments, saturating at STABLE_CYCLES.
- Capture event: fires on the edge where run goes from STABLE_CYCLES-1 to STABLE_CYCLES. Exactly one capture per dwell.
- Latency: with input stable before edge E0, outputs update at edge E0+STABLE_CYCLES-1 (default: 4th edge).
- At capture, by an_q class:
  - Exactly one bit low (index i): digits[i]<=value, digit_valid[i]<=legal, digit_blank[i]<=blank, pattern_err|=invalid, seen[i]<=1.
  - All ones (no digit driven): no update.
  - Two or more low: an_err<=1; no digit updated; seen unchanged.
- A legal capture after an invalid one clears digit_valid/digit_blank accordingly. The sticky flags are cleared only by reset.
- frame_done:
  - When seen becomes all ones (on the capture edge, or held), frame_done=1 for one cycle on the next edge.
  - seen<=0 on that same edge.
  - A capture in that same cycle is still recorded into the fresh seen mask.
- Reset mid-dwell: the run count and partial capture are discarded. No output changes until a full new dwell completes.
- Glitch shorter than STABLE_CYCLES samples: ignored. The restarted run after the glitch produces a new capture of the (possibly same) pattern.

Optional Feature:
- Macro: SEG7_ERRCNT_EN.
- Defined: adds output err_count[7:0], reset 0. Increments by 1 on each invalid-pattern capture and each multi-low-an capture, saturating at 255. Two causes in one event count once.
- Undefined: port and counter absent; remaining behaviour identical.

Decomposition:
- Package seg7_pkg holds:
  - localparams SEG7_D0..SEG7_D9 and SEG7_BLANK (7-bit codes above)
  - DIGIT_NONE=4'hF
  - typedef seg7_t (7-bit) and bcd_t (4-bit)
- One sub-module, seg7_pattern_decode: combinational seg7_t → {bcd_t value, legal, blank}, table-driven from the package. It is shareable with other display checkers.
- seg7_scan_decoder instantiates seg7_pattern_decode once, on seg_q.

Test Plan:
1. Reset, then an=4'b1110, seg7=0010010 held 6 cycles → on 4th edge digits[3:0]=2, digit_valid=4'b0001; no second capture; flags 0.
2. an=1101, seg7=1001111 for 2 cycles, then 0000110 held 5 → digit1 captures 3, never 1; digit_valid[1]=1.
3. Scan digits 0..3 with 0,1,2,3 (5 cycles each) → frame_done pulses once, one cycle after digit3 capture; digits=16'h3210.
4. an=1011, seg7=1111110 held 4 → digits[11:8]=F, digit_valid[2]=0, pattern_err=1. Then seg7=1111111 → digit_blank[2]=1, pattern_err stays 1.
5. an=1100 held 4 cycles → an_err=1, digits unchanged. With SEG7_ERRCNT_EN: err_count=1; after 300 such dwells, err_count=255.
6. Assert rst_n=0 mid-dwell (run=3) → all outputs at reset values immediately. Release → capture only after 4 new stable cycles.
